// File: rtl/osd_avalon_regbank.sv
// osd_avalon_regbank: Avalon-MM register bank with byte enables, read-only status words and frame-synchronous shadow registers
//  Ports: i_clk/i_rst clock and async active-high reset; i_av_* Avalon-MM slave (no waitrequest);
//  o_av_readdata/o_av_readdatavalid registered read response; i_frame_start commit strobe;
//  i_status_in read-only words; o_conduit_signal active register values; o_commit_pending/o_commit_done commit status.
module osd_avalon_regbank #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter logic [(1<<ADDR_WIDTH)-1:0] RO_MASK = '0,
  parameter logic [(1<<ADDR_WIDTH)-1:0] SHADOW_MASK = '0
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [ADDR_WIDTH-1:0]                   i_av_address,
  input  logic                                    i_av_read,
  input  logic                                    i_av_write,
  input  logic [DATA_WIDTH/8-1:0]                 i_av_byteenable,
  input  logic [DATA_WIDTH-1:0]                   i_av_writedata,
  output logic [DATA_WIDTH-1:0]                   o_av_readdata,
  output logic                                    o_av_readdatavalid,
  input  logic                                    i_frame_start,
  input  logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0]   i_status_in,
  output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0]   o_conduit_signal,
  output logic                                    o_commit_pending,
  output logic                                    o_commit_done
);
  localparam int ADDR_NUM = 1 << ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  // read-only wins over shadow
  localparam logic [ADDR_NUM-1:0] SH_MASK = SHADOW_MASK & ~RO_MASK;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_active [ADDR_NUM];
  logic [DATA_WIDTH-1:0] r_shadow [ADDR_NUM];
  logic [DATA_WIDTH-1:0] r_readdata;
  logic                  r_rvalid;
  logic                  r_commit_done;
  logic [DATA_WIDTH-1:0] w_bmask;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_wval;
  logic [DATA_WIDTH-1:0] w_rd;
  logic                  w_wr_rw;
  logic                  w_wr_sh;
  logic                  w_commit;
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < BE_WIDTH; b++) w_bmask[8*b +: 8] = {8{i_av_byteenable[b]}};
  end
  // shadow regs read back and merge against the pending value, others against the active value
  assign w_base   = SH_MASK[i_av_address] ? r_shadow[i_av_address] : r_active[i_av_address];
  assign w_wval   = (w_base & ~w_bmask) | (i_av_writedata & w_bmask);
  assign w_rd     = RO_MASK[i_av_address] ? i_status_in[DATA_WIDTH*i_av_address +: DATA_WIDTH] : w_base;
  assign w_wr_rw  = i_av_write & ~RO_MASK[i_av_address] & ~SH_MASK[i_av_address];
  assign w_wr_sh  = i_av_write & SH_MASK[i_av_address];
  assign w_commit = (r_state == PENDING) & i_frame_start;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ADDR_NUM; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_state       <= IDLE;
      r_readdata    <= '0;
      r_rvalid      <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_rvalid      <= i_av_read;
      r_commit_done <= w_commit;
      if (i_av_read) r_readdata <= w_rd;
      // a shadow write colliding with frame_start keeps the FSM pending for the next frame
      r_state <= w_wr_sh ? PENDING : w_commit ? IDLE : r_state;
      for (int i = 0; i < ADDR_NUM; i++) begin
        if (w_commit && SH_MASK[i]) r_active[i] <= r_shadow[i];
        if (w_wr_rw && i_av_address == ADDR_WIDTH'(i)) r_active[i] <= w_wval;
        if (w_wr_sh && i_av_address == ADDR_WIDTH'(i)) r_shadow[i] <= w_wval;
      end
    end
  end
  for (genvar g = 0; g < ADDR_NUM; g++) begin : g_conduit
    assign o_conduit_signal[DATA_WIDTH*g +: DATA_WIDTH] =
      RO_MASK[g] ? i_status_in[DATA_WIDTH*g +: DATA_WIDTH] : r_active[g];
  end
  assign o_av_readdata      = r_readdata;
  assign o_av_readdatavalid = r_rvalid;
  assign o_commit_pending   = (r_state == PENDING);
  assign o_commit_done      = r_commit_done;
endmodule
